// File: rtl/l3_miss_arbiter_if.sv
// Miss-port bundle between the L2 caches, the L3 miss arbiter and the L3 read port.
// The arbiter uses the slave view; the environment (L2 caches plus L3) uses the master view.
interface l3_miss_arbiter_if #(
    parameter int REQUESTERS = 4,
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 512
);
    logic [REQUESTERS-1:0] req_en;
    logic [ADDR_W-1:0]     req_addr [REQUESTERS];
    logic [DATA_W-1:0]     resp_data;
    logic [REQUESTERS-1:0] resp_valid;
    logic [ADDR_W-1:0]     l3_addr;
    logic                  l3_read_enable;
    logic [DATA_W-1:0]     l3_out;
    logic                  l3_valid;

    modport master (
        output req_en, req_addr, l3_out, l3_valid,
        input  resp_data, resp_valid, l3_addr, l3_read_enable
    );

    modport slave (
        input  req_en, req_addr, l3_out, l3_valid,
        output resp_data, resp_valid, l3_addr, l3_read_enable
    );
endinterface

// File: rtl/l3_miss_arbiter.sv
// Round-robin arbiter sharing one L3 read port among REQUESTERS L2 miss ports.
// Optional L3_ARB_COALESCE_EN: one fill also answers every waiting requester with the same address.
module l3_miss_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int CNT_W      = 16,
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 512
) (
    input  logic               clk_in,
    input  logic               rst_in,
    l3_miss_arbiter_if.slave   bus,
    output logic               busy,
    output logic [CNT_W-1:0]   fill_count
);

    localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(REQUESTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      owner;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_found;
    logic [SUM_W-1:0]      cand;
    logic [REQUESTERS-1:0] fill_mask;
    logic                  fill_fire;

    assign fill_fire = (state_q == S_WAIT) && bus.l3_valid && bus.l3_read_enable;

    // First requester at or after rr_ptr, wrapping past REQUESTERS-1.
    always_comb begin
        // NOTE: every variable gets a default first so no path holds a stale value (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            cand = {1'b0, rr_ptr} + SUM_W'(k);
            if (cand >= SUM_W'(REQUESTERS)) begin
                cand = cand - SUM_W'(REQUESTERS);
            end
            if (!grant_found && bus.req_en[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        fill_mask        = '0;
        fill_mask[owner] = 1'b1;
`ifdef L3_ARB_COALESCE_EN
        for (int i = 0; i < REQUESTERS; i++) begin
            if (bus.req_en[i] && (bus.req_addr[i] == bus.l3_addr)) begin
                fill_mask[i] = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_found) state_d = S_WAIT;
            S_WAIT:  if (fill_fire)   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RESP never arbitrates, giving a served requester one cycle to drop req_en.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr             <= '0;
            owner              <= '0;
            bus.l3_addr        <= '0;
            bus.l3_read_enable <= 1'b0;
            bus.resp_data      <= '0;
            bus.resp_valid     <= '0;
            fill_count         <= '0;
            busy               <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            busy <= (state_d != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        owner              <= grant_idx;
                        bus.l3_addr        <= bus.req_addr[grant_idx];
                        bus.l3_read_enable <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (fill_fire) begin
                        bus.resp_data      <= bus.l3_out;
                        bus.resp_valid     <= fill_mask;
                        bus.l3_read_enable <= 1'b0;
                        rr_ptr             <= (owner == LAST_IDX) ? '0 : owner + PTR_W'(1);
                        if (fill_count != '1) begin
                            fill_count <= fill_count + CNT_W'(1);
                        end
                    end
                end
                S_RESP: begin
                    bus.resp_valid <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/l3_miss_arbiter.md
# l3_miss_arbiter

Shares the single L3 read port among up to REQUESTERS L2 caches. Each L2 cache raises a miss request with a block address. The arbiter picks one request at a time in round-robin order and runs one L3 transaction for it. It then returns the filled block with a one-cycle response pulse. The block sits between the `l2_cache` instances' L3 interfaces and the L3 cache.

## Interface
- `REQUESTERS`, 4: number of L2 miss ports; must be ≥2.
- `CNT_W`, 16: width of the fill counter.
- `clk_in` in 1: clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `req_en` in [REQUESTERS]: miss request per requester. Held with a stable address until the requester sees `resp_valid`.
- `req_addr` in BlockPos[REQUESTERS]: miss address per requester.
- `resp_data` out BlockType: filled block, shared by all requesters.
- `resp_valid` out [REQUESTERS]: one-cycle fill pulse per requester.
- `l3_addr` out BlockPos: address sent to L3.
- `l3_read_enable` out 1: L3 read request.
- `l3_out` in BlockType: L3 data.
- `l3_valid` in 1: L3 data valid.
- `busy` out 1: high when the state is not IDLE.
- `fill_count` out CNT_W: number of completed L3 fills; saturates at all-ones.

## Operation
- The FSM has three states: IDLE, WAIT, RESP. All outputs are registered.
- **IDLE**
  - If any `req_en` is set, grant the first set bit at or after `rr_ptr`, searching upward with wrap.
  - On grant: latch `owner` and `l3_addr <= req_addr[owner]`, set `l3_read_enable <= 1`, go to WAIT.
  - If no `req_en` is set, stay in IDLE.
- **WAIT**
  - Hold `l3_addr` and `l3_read_enable` stable.
  - When `l3_valid && l3_read_enable`:
    - `resp_data <= l3_out`, `resp_valid[owner] <= 1`, `l3_read_enable <= 0`.
    - `rr_ptr <= owner+1`, wrapping to 0 after REQUESTERS-1.
    - `fill_count` increments, saturating.
    - Go to RESP.
- **RESP**
  - `resp_valid` is high for exactly this cycle; clear it at the next edge.
  - No arbitration happens in RESP. This gives the requester one cycle to drop `req_en`.
  - Go to IDLE.
- **Requester withdrawal.** If `req_en[owner]` drops during WAIT, the L3 transaction still completes and `resp_valid[owner]` still pulses. The requester ignores it.
- **Request ignored while waiting.** `l3_valid` seen while in IDLE or RESP is ignored.
- **Reset.** Asserting `rst_in` at any time, including mid-transaction, immediately sets:
  - state IDLE, `rr_ptr`=0, `owner`=0;
  - `l3_read_enable`=0, `l3_addr`=0;
  - `resp_data`=0, `resp_valid`=0;
  - `fill_count`=0, `busy`=0.
- **Fairness.** The requester granted last has the lowest priority next time. Any requester holding `req_en` is served within REQUESTERS grants.

## Timing
- Latency from a grant in IDLE at edge t: `l3_read_enable` is high from t.
- L3 returns `l3_valid` at edge t+L, with L ≥ 1.
- `resp_valid` is high during cycle t+L through t+L+1.
- The next grant can happen at the earliest at edge t+L+2.
- Minimum spacing between fills is 3 cycles.
- `busy` is high from the grant edge until the edge that returns the FSM to IDLE.
- All outputs change only on `clk_in` rising edges, except on asynchronous reset.

## Configuration
- Macro: `L3_ARB_COALESCE_EN`.
- **Defined:** on a fill, assert `resp_valid[i]` for every i with `req_en[i] && req_addr[i]==l3_addr`, plus `owner`.
  - All of those requesters see the same `resp_data` in the same RESP cycle.
  - `rr_ptr` still advances from `owner` only.
  - `fill_count` increments by 1 regardless of how many requesters are served.
- **Undefined:** only `resp_valid[owner]` pulses. Each duplicate address causes its own L3 read.

## Test plan
- **Reset:** assert `rst_in` mid-WAIT with `l3_addr`=0x12 → `l3_read_enable`, `resp_valid`, `busy`, `fill_count` all 0 immediately; state is IDLE after release.
- **Single miss:** `req_en`=0001, addr 0x05; L3 returns 0xAA after 3 cycles → `l3_addr`=0x05; `resp_valid`=0001 for exactly 1 cycle with `resp_data`=0xAA; `fill_count`=1.
- **Round-robin:** `req_en`=1111 held, each addr distinct, L3 latency 1 → grant order 0,1,2,3,0; fills 3 cycles apart.
- **Withdrawal:** requester 2 granted, drops `req_en` in WAIT → fill completes; `resp_valid`=0100 pulses; next grant goes to requester 3.
- **Coalescing, with `L3_ARB_COALESCE_EN`:** requesters 0 and 3 both request 0x40 → single L3 read; `resp_valid`=1001; `fill_count`=1.
- **Coalescing, without the macro:** same stimulus → two L3 reads; `fill_count`=2.
- **Saturation:** with `CNT_W`=2, run 5 fills → `fill_count` reads 3.
